// File: rtl/imm_encoder.sv
// Immediate encoder: scatters a range-checked immediate into the fields of a base instruction.
// Latency: 2 cycles from accept to out_valid (stage A encode register, stage B output register).
// Backpressure: out_ready low holds stage B; stage A fills, then in_ready drops (2 items in flight).
module imm_encoder #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           fmt,
  input  logic [31:0]          base,
  input  logic [31:0]          imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          instr,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [2:0] FMT_I = 3'b000;
  localparam logic [2:0] FMT_U = 3'b001;
  localparam logic [2:0] FMT_S = 3'b010;
  localparam logic [2:0] FMT_B = 3'b011;
  localparam logic [2:0] FMT_J = 3'b100;

  localparam logic [ERR_CNT_W-1:0] CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

  logic signed [31:0] simm;
  logic [31:0]        enc_instr;
  logic               enc_err;

  logic               a_valid;
  logic [31:0]        a_instr;
  logic               a_err;

  logic               b_load;
  logic               a_load;

  assign simm = imm;

  // Encode: replace the immediate field of base with imm bits; flag out-of-range or illegal format.
  // Out-of-range immediates are still encoded from their truncated bits so the loader sees something.
  always_comb begin
    enc_instr = base;
    enc_err   = 1'b1;
    case (fmt)
      FMT_I: begin
        enc_instr = {imm[11:0], base[19:0]};
        enc_err   = (simm < -32'sd2048) || (simm > 32'sd2047);
      end
      FMT_S: begin
        enc_instr = {imm[11:5], base[24:12], imm[4:0], base[6:0]};
        enc_err   = (simm < -32'sd2048) || (simm > 32'sd2047);
      end
      FMT_B: begin
        enc_instr = {imm[12], imm[10:5], base[24:12], imm[4:1], imm[11], base[6:0]};
        enc_err   = (simm < -32'sd4096) || (simm > 32'sd4094) || imm[0];
      end
      FMT_U: begin
        enc_instr = {imm[31:12], base[11:0]};
        enc_err   = |imm[11:0];
      end
      FMT_J: begin
        enc_instr = {imm[20], imm[10:1], imm[11], imm[19:12], base[11:0]};
        enc_err   = (simm < -32'sd1048576) || (simm > 32'sd1048574) || imm[0];
      end
      default: begin
        enc_instr = base;
        enc_err   = 1'b1;
      end
    endcase
  end

  // Pipeline control: B advances when empty or draining; A advances when empty or B advances.
  assign b_load   = !out_valid || out_ready;
  assign a_load   = !a_valid || b_load;
  assign in_ready = rst_n && a_load;

  // Stage A register: captures the encoded word on each accepted request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_valid <= 1'b0;
      a_instr <= 32'h0;
      a_err   <= 1'b0;
    end else if (a_load) begin
      a_valid <= in_valid;
      if (in_valid) begin
        a_instr <= enc_instr;
        a_err   <= enc_err;
      end
    end
  end

  // Stage B output register: held stable while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      instr     <= 32'h0;
      err       <= 1'b0;
    end else if (b_load) begin
      out_valid <= a_valid;
      if (a_valid) begin
        instr <= a_instr;
        err   <= a_err;
      end
    end
  end

  // Error counter: counts errored words as they leave, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (out_valid && out_ready && err && (err_count != '1)) begin
      err_count <= err_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: vector table streamed at full rate, plus latency, stall, saturation and reset sequences.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  fmt;
  logic [31:0] base;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic        err;
  logic [7:0]  err_count;

  imm_encoder #(.ERR_CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fmt       (fmt),
    .base      (base),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .instr     (instr),
    .err       (err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  fmt;
    logic [31:0] base;
    logic [31:0] imm;
    logic [31:0] exp_instr;
    logic        exp_err;
  } vec_t;

  vec_t tbl[24];
  vec_t pend[$];
  vec_t exp_q[$];

  int tests     = 0;
  int fails     = 0;
  int model_cnt = 0;
  int out_idx   = 0;

  function automatic vec_t mkv(input logic [2:0] f, input logic [31:0] b, input logic [31:0] i,
                               input logic [31:0] e, input logic ee);
    vec_t v;
    v.fmt = f; v.base = b; v.imm = i; v.exp_instr = e; v.exp_err = ee;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of streaming: present the next pending request, score any output transfer.
  task automatic stream_cycle(input logic ordy);
    vec_t h;
    if (pend.size() > 0) begin
      in_valid = 1'b1;
      fmt      = pend[0].fmt;
      base     = pend[0].base;
      imm      = pend[0].imm;
    end else begin
      in_valid = 1'b0;
    end
    out_ready = ordy;
    #1;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: got instr 0x%08h, expected no output", instr);
      end else begin
        h = exp_q.pop_front();
        chk($sformatf("instr[%0d]", out_idx), instr, h.exp_instr);
        chk($sformatf("err[%0d]", out_idx), 32'(err), 32'(h.exp_err));
        if (h.exp_err && model_cnt < 255) model_cnt++;
        out_idx++;
      end
    end
    if (in_valid && in_ready) exp_q.push_back(pend.pop_front());
    tick();
  endtask

  task automatic drain(input int budget, output int cyc);
    cyc = 0;
    while ((pend.size() + exp_q.size()) > 0 && cyc < budget) begin
      stream_cycle(1'b1);
      cyc++;
    end
    in_valid = 1'b0;
    chk("drain_complete", 32'(pend.size() + exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cyc;

    tbl[0]  = mkv(3'd0, 32'h00000093, 32'd5,        32'h00500093, 1'b0);
    tbl[1]  = mkv(3'd3, 32'h00009063, 32'hFFFFFFFC, 32'hFE009EE3, 1'b0);
    tbl[2]  = mkv(3'd4, 32'h0000006F, 32'd8,        32'h0080006F, 1'b0);
    tbl[3]  = mkv(3'd4, 32'h0000006F, 32'd7,        32'h0060006F, 1'b1);
    tbl[4]  = mkv(3'd0, 32'h00000093, 32'd2048,     32'h80000093, 1'b1);
    tbl[5]  = mkv(3'd0, 32'h00000093, 32'hFFFFF800, 32'h80000093, 1'b0);
    tbl[6]  = mkv(3'd0, 32'hFFF00093, 32'd0,        32'h00000093, 1'b0);
    tbl[7]  = mkv(3'd2, 32'h0020A023, 32'd8,        32'h0020A423, 1'b0);
    tbl[8]  = mkv(3'd2, 32'h0020A023, 32'hFFFFFFFF, 32'hFE20AFA3, 1'b0);
    tbl[9]  = mkv(3'd2, 32'h0020A023, 32'hFFFFF7FF, 32'h7E20AFA3, 1'b1);
    tbl[10] = mkv(3'd3, 32'h00000063, 32'd4094,     32'h7E000FE3, 1'b0);
    tbl[11] = mkv(3'd3, 32'h00000063, 32'd4096,     32'h80000063, 1'b1);
    tbl[12] = mkv(3'd3, 32'h00000063, 32'hFFFFF000, 32'h80000063, 1'b0);
    tbl[13] = mkv(3'd1, 32'h000000B7, 32'h12345000, 32'h123450B7, 1'b0);
    tbl[14] = mkv(3'd1, 32'h000000B7, 32'h12345001, 32'h123450B7, 1'b1);
    tbl[15] = mkv(3'd1, 32'hFFFFF0B7, 32'hABCDE000, 32'hABCDE0B7, 1'b0);
    tbl[16] = mkv(3'd4, 32'h0000006F, 32'h000FFFFE, 32'h7FFFF06F, 1'b0);
    tbl[17] = mkv(3'd4, 32'h0000006F, 32'hFFF00000, 32'h8000006F, 1'b0);
    tbl[18] = mkv(3'd4, 32'h0000006F, 32'h00100000, 32'h8000006F, 1'b1);
    tbl[19] = mkv(3'd5, 32'h12345678, 32'd0,        32'h12345678, 1'b1);
    tbl[20] = mkv(3'd7, 32'hDEADBEEF, 32'd5,        32'hDEADBEEF, 1'b1);
    tbl[21] = mkv(3'd3, 32'h00000063, 32'd3,        32'h00000163, 1'b1);
    tbl[22] = mkv(3'd0, 32'h00000093, 32'd2047,     32'h7FF00093, 1'b0);
    tbl[23] = mkv(3'd0, 32'h00000093, 32'hFFFFF7FF, 32'h7FF00093, 1'b1);

    // Reset state
    rst_n = 1'b0; in_valid = 1'b0; fmt = 3'd0; base = 32'h0; imm = 32'h0; out_ready = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_in_ready_low", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // addi x1,x0,5: out_valid two cycles after accept
    in_valid = 1'b1; fmt = 3'd0; base = 32'h00000093; imm = 32'd5; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("lat_n1_out_valid", 32'(out_valid), 32'd0);
    tick();
    chk("lat_n2_out_valid", 32'(out_valid), 32'd1);
    chk("lat_addi_instr", instr, 32'h00500093);
    chk("lat_addi_err", 32'(err), 32'd0);
    tick();
    chk("lat_after_out_valid", 32'(out_valid), 32'd0);

    // Vector table streamed back-to-back
    foreach (tbl[i]) pend.push_back(tbl[i]);
    drain(100, cyc);
    chk("throughput_cycles", 32'(cyc), 32'd26);
    chk("table_err_count", 32'(err_count), 32'(model_cnt));

    // Backpressure: two accepted, third waits, then drain in order
    out_ready = 1'b0; in_valid = 1'b1; fmt = 3'd0; base = 32'h00000093; imm = 32'd1;
    #1;
    chk("bp_accept0", 32'(in_ready), 32'd1);
    tick();
    imm = 32'd2;
    #1;
    chk("bp_accept1", 32'(in_ready), 32'd1);
    tick();
    imm = 32'd3;
    #1;
    chk("bp_full_in_ready", 32'(in_ready), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    chk("bp_instr0", instr, 32'h00100093);
    tick();
    chk("bp_still_full", 32'(in_ready), 32'd0);
    chk("bp_stall_valid", 32'(out_valid), 32'd1);
    chk("bp_stall_instr", instr, 32'h00100093);
    tick();
    out_ready = 1'b1;
    #1;
    chk("bp_accept2_on_drain", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    #1;
    chk("bp_drain1_valid", 32'(out_valid), 32'd1);
    chk("bp_drain1_instr", instr, 32'h00200093);
    tick();
    chk("bp_drain2_instr", instr, 32'h00300093);
    tick();
    chk("bp_empty", 32'(out_valid), 32'd0);
    chk("bp_err_count", 32'(err_count), 32'(model_cnt));

    // Range error counting and saturation
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_cnt = 0;
    pend.push_back(mkv(3'd0, 32'h00000093, 32'd2048, 32'h80000093, 1'b1));
    drain(20, cyc);
    chk("err_count_one", 32'(err_count), 32'd1);
    for (int k = 0; k < 259; k++) pend.push_back(mkv(3'd0, 32'h00000093, 32'd2048, 32'h80000093, 1'b1));
    drain(400, cyc);
    chk("err_count_sat", 32'(err_count), 32'd255);
    pend.push_back(mkv(3'd5, 32'h00000013, 32'd0, 32'h00000013, 1'b1));
    drain(20, cyc);
    chk("err_count_held", 32'(err_count), 32'd255);

    // Reset with two items in flight
    out_ready = 1'b0; in_valid = 1'b1; fmt = 3'd4; base = 32'h0000006F; imm = 32'd7;
    tick();
    imm = 32'd8;
    tick();
    in_valid = 1'b0;
    chk("mid_inflight_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_err_count", 32'(err_count), 32'd0);
    chk("mid_rst_instr", instr, 32'h0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    pend.push_back(mkv(3'd1, 32'h000000B7, 32'h12345000, 32'h123450B7, 1'b0));
    drain(20, cyc);
    for (int k = 0; k < 4; k++) begin
      stream_cycle(1'b1);
      chk($sformatf("mid_idle[%0d]", k), 32'(out_valid), 32'd0);
    end
    chk("mid_err_count", 32'(err_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
